// File: rtl/ac_match_sequencer_if.sv
// Bundle of the character handshake, goto/failure table read ports and
// the automaton state report shared by the sequencer and its neighbours.
interface ac_match_sequencer_if #(
  parameter int STATE_W = 8,
  parameter int CHAR_W  = 4,
  parameter int ADDR_W  = 5
);
  logic               clr;
  logic               char_valid;
  logic [CHAR_W-1:0]  char_in;
  logic               char_ready;
  logic               goto_rd;
  logic [ADDR_W-1:0]  goto_addr;
  logic [STATE_W-1:0] goto_cur;
  logic [CHAR_W-1:0]  goto_chr;
  logic [STATE_W-1:0] goto_nxt;
  logic               fail_rd;
  logic [STATE_W-1:0] fail_addr;
  logic [STATE_W-1:0] fail_state;
  logic [STATE_W-1:0] now_state;
  logic               state_valid;
  logic               loop_err;

  // sequencer side
  modport master (
    input  clr, char_valid, char_in, goto_cur, goto_chr, goto_nxt, fail_state,
    output char_ready, goto_rd, goto_addr, fail_rd, fail_addr,
           now_state, state_valid, loop_err
  );

  // character source / table RAM side
  modport slave (
    output clr, char_valid, char_in, goto_cur, goto_chr, goto_nxt, fail_state,
    input  char_ready, goto_rd, goto_addr, fail_rd, fail_addr,
           now_state, state_valid, loop_err
  );
endinterface

// File: rtl/ac_match_sequencer.sv
// Aho-Corasick match sequencer: per accepted character, linearly scans the
// goto table for (state, char) and follows failure links on a miss, bounded
// by a per-character hop limit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a character, char_ready high
// SCAN      | streaming goto reads, comparing entry of previous address
// FAIL_REQ  | failure table read strobe for now_state
// FAIL_WAIT | failure target returned, adopt it and rescan from entry 0
module ac_match_sequencer #(
  parameter int STATE_W    = 8,
  parameter int CHAR_W     = 4,
  parameter int GOTO_DEPTH = 32,
  parameter int ADDR_W     = 5,
  parameter int MAX_HOPS   = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  ac_match_sequencer_if.master bus
);

  localparam int HOP_W = $clog2(MAX_HOPS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GOTO_DEPTH - 1);
  localparam logic [HOP_W-1:0]  HOP_MAX   = HOP_W'(MAX_HOPS);

  typedef enum logic [1:0] {IDLE, SCAN, FAIL_REQ, FAIL_WAIT} state_t;

  state_t             state;
  logic [CHAR_W-1:0]  char_q;
  logic [HOP_W-1:0]   hop_cnt;
  logic               rd_q;      // table data this cycle answers a read
  logic [ADDR_W-1:0]  addr_q;    // address that data belongs to
  logic [STATE_W-1:0] now_state;
  logic               state_valid;
  logic               loop_err;
  logic               goto_rd;
  logic [ADDR_W-1:0]  goto_addr;
  logic               fail_rd;
  logic [STATE_W-1:0] fail_addr;
  logic               scan_hit;
  logic               scan_end;

  // Entry comparison against the state current at compare time; a hit wins
  // over end-of-table on the same entry.
  always_comb begin
    scan_hit = rd_q && (bus.goto_cur == now_state) && (bus.goto_chr == char_q);
    scan_end = rd_q && !scan_hit &&
               ((bus.goto_cur == '1) || (addr_q == LAST_ADDR));
  end

  // Sequencer FSM with registered table strobes and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      char_q      <= '0;
      hop_cnt     <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      now_state   <= '0;
      state_valid <= 1'b0;
      loop_err    <= 1'b0;
      goto_rd     <= 1'b0;
      goto_addr   <= '0;
      fail_rd     <= 1'b0;
      fail_addr   <= '0;
    end else begin
      state_valid <= 1'b0;
      loop_err    <= 1'b0;
      fail_rd     <= 1'b0;
      rd_q        <= goto_rd;
      addr_q      <= goto_addr;
      if (bus.clr) begin
        state     <= IDLE;
        now_state <= '0;
        goto_rd   <= 1'b0;
        goto_addr <= '0;
        rd_q      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.char_valid) begin
              char_q    <= bus.char_in;
              hop_cnt   <= '0;
              goto_rd   <= 1'b1;
              goto_addr <= '0;
              state     <= SCAN;
            end
          end
          SCAN: begin
            if (scan_hit) begin
              now_state   <= bus.goto_nxt;
              state_valid <= 1'b1;
              goto_rd     <= 1'b0;
              state       <= IDLE;
            end else if (scan_end) begin
              goto_rd <= 1'b0;
              if (now_state == '0) begin
                state_valid <= 1'b1;
                state       <= IDLE;
              end else if (hop_cnt == HOP_MAX) begin
                now_state   <= '0;
                state_valid <= 1'b1;
                loop_err    <= 1'b1;
                state       <= IDLE;
              end else begin
                fail_rd   <= 1'b1;
                fail_addr <= now_state;
                state     <= FAIL_REQ;
              end
            end else if (goto_rd && (goto_addr != LAST_ADDR)) begin
              goto_addr <= goto_addr + ADDR_W'(1);
            end else begin
              // last entry already requested; wait for its compare
              goto_rd <= 1'b0;
            end
          end
          FAIL_REQ: begin
            state <= FAIL_WAIT;
          end
          FAIL_WAIT: begin
            now_state <= bus.fail_state;
            hop_cnt   <= hop_cnt + HOP_W'(1);
            goto_rd   <= 1'b1;
            goto_addr <= '0;
            state     <= SCAN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.char_ready  = (state == IDLE) && !bus.clr;
  assign bus.goto_rd     = goto_rd;
  assign bus.goto_addr   = goto_addr;
  assign bus.fail_rd     = fail_rd;
  assign bus.fail_addr   = fail_addr;
  assign bus.now_state   = now_state;
  assign bus.state_valid = state_valid;
  assign bus.loop_err    = loop_err;

endmodule
